// File: rtl/fp_add_pkg.sv
// Shared types and sizing for the FP adder sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_add_pkg;

  // Default operand/result width in bits.
  localparam int FP_WIDTH = 32;

  // Counter must be able to hold FP_WIDTH itself.
  localparam int FP_CNT_W = $clog2(FP_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_START,
    ST_WAIT,
    ST_SHIFT_OUT
  } state_t;

endpackage

// File: rtl/fp_add_ser_out.sv
// Result parallel-to-serial register: loads a WIDTH-bit word, emits it LSB first.
// Latency: first bit valid the cycle after load_vld; one bit per accepted handshake.
// Backpressure: ser_rdy low holds ser_dat/ser_vld stable indefinitely.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load_vld/load_dat  capture a new result word and start streaming
//   ser_dat/ser_vld    current result bit and its valid
//   ser_rdy            consumer accepts the current bit
//   last_hs            high in the cycle the final bit is handshaken
module fp_add_ser_out #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  output logic             ser_dat,
  output logic             ser_vld,
  input  logic             ser_rdy,
  output logic             last_hs
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             vld_q;
  logic             hs;

  assign hs      = vld_q && ser_rdy;
  assign last_hs = hs && (bit_cnt_q == CW'(WIDTH - 1));
  assign ser_dat = shreg_q[0];
  assign ser_vld = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      vld_q     <= 1'b0;
    end else if (load_vld) begin
      shreg_q   <= load_dat;
      bit_cnt_q <= '0;
      vld_q     <= 1'b1;
    end else if (hs) begin
      shreg_q <= shreg_q >> 1;
      if (last_hs) begin
        bit_cnt_q <= '0;
        vld_q     <= 1'b0;
      end else begin
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Sequencer between a bit-serial host link and the FP adder: loads A then B, starts the adder, streams the sum back.
// Latency: START the cycle after the last B bit; first result bit valid the cycle after add_done_in.
// Backpressure: host_rdy_out low outside IDLE/LOAD_A/LOAD_B; res_rdy_in low stalls the result stream.
//
// Ports:
//   clk_in, rst_in                    clock, asynchronous active-low reset
//   host_serial_in/host_wr_in         serial operand bit + write qualifier (A bits then B bits, LSB first)
//   host_rdy_out                      a host bit will be accepted this cycle
//   sr_serial_out, a_wr_out, b_wr_out operand shift-register data and write strobes (combinational)
//   add_start_out                     one-cycle adder start
//   add_done_in, add_result_in        adder result valid (sampled in WAIT only) and sum
//   res_serial_out/res_valid_out      result bit (LSB first) and valid; res_rdy_in accepts it
//   busy_out                          not IDLE
//   err_out                           sticky watchdog timeout, cleared by the next accepted host bit
//
// Optional build macro FP_ADD_SEQ_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT cycles driving err_out.
// Without it WAIT is unbounded and err_out is constant 0.
module fp_add_seq_ctrl
  import fp_add_pkg::*;
#(
  parameter int WIDTH   = FP_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             host_serial_in,
  input  logic             host_wr_in,
  output logic             host_rdy_out,
  output logic             sr_serial_out,
  output logic             a_wr_out,
  output logic             b_wr_out,
  output logic             add_start_out,
  input  logic             add_done_in,
  input  logic [WIDTH-1:0] add_result_in,
  output logic             res_serial_out,
  output logic             res_valid_out,
  input  logic             res_rdy_in,
  output logic             busy_out,
  output logic             err_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          in_a_phase;
  logic          host_acc;
  logic          res_load;
  logic          ser_last;
  logic          wd_expire;

  // IDLE counts as the A phase: the very first accepted bit is A bit 0.
  assign in_a_phase    = (state_q == ST_IDLE) || (state_q == ST_LOAD_A);
  assign host_rdy_out  = in_a_phase || (state_q == ST_LOAD_B);
  assign host_acc      = host_wr_in && host_rdy_out;
  assign sr_serial_out = host_serial_in;
  assign a_wr_out      = host_wr_in && in_a_phase;
  assign b_wr_out      = host_wr_in && (state_q == ST_LOAD_B);
  assign add_start_out = (state_q == ST_START);
  assign busy_out      = (state_q != ST_IDLE);

`ifdef FP_ADD_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // Expiry is the last WAIT cycle of the budget; a done in that same cycle takes priority in the FSM.
  assign wd_expire = (state_q == ST_WAIT) && (wd_q == WD_W'(TIMEOUT - 1));
  assign err_out   = err_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == ST_WAIT) ? wd_q + WD_W'(1) : '0;
      if (wd_expire && !add_done_in) begin
        err_q <= 1'b1;
      end else if (host_acc) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  // No watchdog in this build: WAIT never expires for any legal TIMEOUT.
  assign wd_expire = (TIMEOUT < 0);
  assign err_out   = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    res_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (host_wr_in) begin
          bit_cnt_d = CW'(1);
          state_d   = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        if (host_wr_in) begin
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_LOAD_B;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (host_wr_in) begin
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_START;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      // add_done_in is deliberately not looked at here.
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (add_done_in) begin
          res_load  = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT_OUT;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT_OUT: begin
        if (ser_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fp_add_ser_out #(
    .WIDTH (WIDTH)
  ) u_ser_out (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .load_vld (res_load),
    .load_dat (add_result_in),
    .ser_dat  (res_serial_out),
    .ser_vld  (res_valid_out),
    .ser_rdy  (res_rdy_in),
    .last_hs  (ser_last)
  );

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed bench for fp_add_seq_ctrl with a 3-cycle adder model and a result scoreboard.
// Latency: n/a.
// Backpressure: exercises res_rdy_in stalls and host writes outside the load phases.
module tb_fp_add_seq_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_serial = 1'b0;
  logic          host_wr = 1'b0;
  logic          host_rdy_out;
  logic          sr_serial_out;
  logic          a_wr_out;
  logic          b_wr_out;
  logic          add_start_out;
  logic          add_done = 1'b0;
  logic [W-1:0]  add_result = '0;
  logic          res_serial_out;
  logic          res_valid_out;
  logic          res_rdy = 1'b0;
  logic          busy_out;
  logic          err_out;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [W-1:0]  exp_q[$];

  int            a_cnt, b_cnt, start_cnt, sr_bad;
  logic [W-1:0]  cap_a, cap_b;
  bit            model_en = 1'b1;
  bit            early_done = 1'b0;
  int            lat = 3;

  always #5 clk = ~clk;

  fp_add_seq_ctrl #(
    .WIDTH   (W),
    .TIMEOUT (64)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .host_serial_in (host_serial),
    .host_wr_in     (host_wr),
    .host_rdy_out   (host_rdy_out),
    .sr_serial_out  (sr_serial_out),
    .a_wr_out       (a_wr_out),
    .b_wr_out       (b_wr_out),
    .add_start_out  (add_start_out),
    .add_done_in    (add_done),
    .add_result_in  (add_result),
    .res_serial_out (res_serial_out),
    .res_valid_out  (res_valid_out),
    .res_rdy_in     (res_rdy),
    .busy_out       (busy_out),
    .err_out        (err_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Adder model: known IEEE-754 single-precision sums of the operand pairs used below.
  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    ab = {a, b};
    case (ab)
      {32'h3F800000, 32'h40000000}: return 32'h40400000;  // 1.0 + 2.0
      {32'h40400000, 32'h40800000}: return 32'h40E00000;  // 3.0 + 4.0
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;  // 0.5 + 0.5
      {32'hC0000000, 32'h3F800000}: return 32'hBF800000;  // -2.0 + 1.0
      default:                      return 32'hFFFFFFFF;
    endcase
  endfunction

  always begin
    @(negedge clk);
    if (add_start_out) begin
      start_cnt++;
      if (model_en) begin
        if (early_done) begin
          add_done   = 1'b1;
          add_result = 32'hDEADBEEF;
        end
        @(negedge clk);
        add_done = 1'b0;
        repeat (lat - 1) @(negedge clk);
        add_done   = 1'b1;
        add_result = fp_sum(cap_a, cap_b);
        @(negedge clk);
        add_done   = 1'b0;
        add_result = '0;
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    host_wr     = 1'b1;
    host_serial = b;
    #1;
    if (sr_serial_out !== b) sr_bad++;
    if (a_wr_out) begin
      a_cnt++;
      cap_a = {sr_serial_out, cap_a[W-1:1]};
    end
    if (b_wr_out) begin
      b_cnt++;
      cap_b = {sr_serial_out, cap_b[W-1:1]};
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
  endtask

  task automatic txn_reset_counts();
    a_cnt = 0; b_cnt = 0; start_cnt = 0; sr_bad = 0;
    cap_a = '0; cap_b = '0;
  endtask

  task automatic recv(input int stall_bit, input bit poke);
    logic [W-1:0] got;
    int guard, vld_bad, poke_bad, stall_bad;
    got = '0; guard = 0; vld_bad = 0; poke_bad = 0; stall_bad = 0;
    while (!res_valid_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("res_valid_rise", {31'd0, res_valid_out}, 32'd1);
    for (int i = 0; i < W; i++) begin
      if (res_valid_out !== 1'b1) vld_bad++;
      got[i] = res_serial_out;
      if (poke) begin
        host_wr     = (i != W - 1);
        host_serial = 1'b1;
        #1;
        if (a_wr_out || b_wr_out || host_rdy_out) poke_bad++;
      end
      if (i == stall_bit) begin
        res_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (res_valid_out !== 1'b1 || res_serial_out !== got[i]) stall_bad++;
        end
        check("stall_stable", stall_bad, 0);
      end
      res_rdy = 1'b1;
      @(negedge clk);
    end
    host_wr = 1'b0;
    res_rdy = 1'b0;
    check("res_valid_held", vld_bad, 0);
    if (poke) check("shift_poke_no_strobe", poke_bad, 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      check("result", got, exp_q.pop_front());
    end
    #1;
    check("end_res_valid", {31'd0, res_valid_out}, 32'd0);
    check("end_busy", {31'd0, busy_out}, 32'd0);
    check("end_host_rdy", {31'd0, host_rdy_out}, 32'd1);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum,
                     input bit poke, input int stall_bit, input bit early);
    txn_reset_counts();
    early_done = early;
    exp_q.push_back(sum);
    send_word(a, W);
    send_word(b, W);
    // START cycle
    @(negedge clk);
    host_wr     = poke;
    host_serial = 1'b1;
    #1;
    check("start_pulse", {31'd0, add_start_out}, 32'd1);
    check("start_host_rdy", {30'd0, host_rdy_out, a_wr_out | b_wr_out}, 32'd0);
    // first WAIT cycle
    @(negedge clk);
    #1;
    check("wait_quiet", {29'd0, add_start_out, host_rdy_out, a_wr_out | b_wr_out}, 32'd0);
    host_wr = 1'b0;
    recv(stall_bit, poke);
    check("a_wr_count", a_cnt, W);
    check("b_wr_count", b_cnt, W);
    check("start_count", start_cnt, 1);
    check("captured_a", cap_a, a);
    check("captured_b", cap_b, b);
    check("sr_serial_copy", sr_bad, 0);
    early_done = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_host_rdy", {31'd0, host_rdy_out}, 32'd1);
    check("rst_outputs", {26'd0, a_wr_out, b_wr_out, add_start_out, res_valid_out, busy_out, err_out}, 32'd0);
    check("rst_res_serial", {31'd0, res_serial_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic transfer, 1.0 + 2.0
    txn(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, -1, 1'b0);
    // Stall at result bit 7
    txn(32'h40400000, 32'h40800000, 32'h40E00000, 1'b0, 7, 1'b0);
    // Host writes during START/WAIT/SHIFT_OUT are ignored
    txn(32'h3F000000, 32'h3F000000, 32'h3F800000, 1'b1, -1, 1'b0);

    // Reset after 20 B bits
    txn_reset_counts();
    send_word(32'h3F800000, W);
    send_word(32'h40000000, 20);
    @(negedge clk);
    host_wr = 1'b0;
    #1;
    check("pre_abort_busy", {31'd0, busy_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_host_rdy", {31'd0, host_rdy_out}, 32'd1);
    check("abort_outputs", {26'd0, a_wr_out, b_wr_out, add_start_out, res_valid_out, busy_out, err_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0, -1, 1'b0);

    // Done pulse during START must be ignored
    txn(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, -1, 1'b1);

`ifdef FP_ADD_SEQ_TIMEOUT_EN
    begin
      int cyc;
      bit saw_vld;
      cyc = 0;
      saw_vld = 1'b0;
      model_en = 1'b0;
      txn_reset_counts();
      send_word(32'h3F800000, W);
      send_word(32'h40000000, W);
      @(negedge clk);
      host_wr = 1'b0;
      cyc = 1;
      while (busy_out && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (res_valid_out) saw_vld = 1'b1;
      end
      // 1 START cycle + 64 WAIT cycles, observed in the first IDLE cycle
      check("timeout_cycles", cyc, 66);
      check("timeout_err", {31'd0, err_out}, 32'd1);
      check("timeout_no_result", {31'd0, saw_vld}, 32'd0);
      send_bit(1'b0);
      @(negedge clk);
      host_wr = 1'b0;
      #1;
      check("err_cleared", {31'd0, err_out}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_en = 1'b1;
    end
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_seq_ctrl.md
Name: fp_add_seq_ctrl

Overview:
Sequencer that sits between a bit-serial host link and the FP adder datapath. It steers the incoming serial stream into the operand-A and operand-B shift registers, 32 bits each, and pulses the adder start. It then captures the 32-bit sum and streams it back to the host bit-serially with a valid/ready handshake.

Parameters:
WIDTH, 32, operand and result width in bits; the counter is sized to hold WIDTH.
TIMEOUT, 64, maximum cycles in WAIT before an error; used only with the optional feature.

Ports:
clk_in  input  1  single clock; all logic on rising edge
rst_in  input  1  asynchronous, active-low reset
host_serial_in  input  1  serial operand bit; A bits first, then B bits, LSB first
host_wr_in  input  1  qualifies host_serial_in for one cycle
host_rdy_out  output  1  high when a host bit will be accepted
sr_serial_out  output  1  copy of host_serial_in, wired to both operand shift registers
a_wr_out  output  1  write strobe for the operand-A shift register
b_wr_out  output  1  write strobe for the operand-B shift register
add_start_out  output  1  one-cycle start pulse to the adder
add_done_in  input  1  adder result valid, sampled only in WAIT
add_result_in  input  WIDTH  adder sum
res_serial_out  output  1  result bit, LSB first
res_valid_out  output  1  res_serial_out is valid
res_rdy_in  input  1  host accepts the current result bit
busy_out  output  1  high in every state except IDLE
err_out  output  1  sticky timeout flag; cleared on the next accepted host bit

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=IDLE; bit_cnt=0; result register=0.
  - All outputs 0, except host_rdy_out, which is 1 as in IDLE.
- Reset mid-operation aborts the transaction immediately; partial operand bits are discarded.
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, SHIFT_OUT.
- host_rdy_out is 1 in IDLE, LOAD_A and LOAD_B; host_wr_in in any other state is ignored and produces no strobe.
- a_wr_out = host_wr_in in IDLE or LOAD_A; b_wr_out = host_wr_in in LOAD_B. Both are combinational, zero-latency pass-through; sr_serial_out = host_serial_in.
- IDLE: an accepted bit counts as A bit 0, sets bit_cnt=1 and moves to LOAD_A.
- LOAD_A: each accepted bit increments bit_cnt. On the WIDTH-th bit, bit_cnt resets to 0 and the state moves to LOAD_B.
- LOAD_B: same counting; the WIDTH-th bit moves to START.
- START: add_start_out=1 for exactly one cycle, then WAIT.
- WAIT: on add_done_in=1, latch add_result_in into the result register, set bit_cnt=0 and go to SHIFT_OUT.
  - add_done_in in the START cycle is ignored.
- SHIFT_OUT:
  - res_valid_out=1; res_serial_out = result register bit 0.
  - When res_valid_out and res_rdy_in are both high, shift the result register right by one and increment bit_cnt.
  - After the WIDTH-th handshake, go to IDLE; res_valid_out falls in the next cycle.
  - Holding res_rdy_in low stalls the block indefinitely with the current bit held stable.
- Latency: START is entered the cycle after the last B bit; the first result bit is valid the cycle after add_done_in.
- Handshake boundary: result bit WIDTH-1 and a new host bit cannot overlap, because host_rdy_out=0 during SHIFT_OUT.

Optional Feature:
FP_ADD_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles in WAIT.
  - If TIMEOUT cycles pass without add_done_in, set err_out=1 and return to IDLE with no result output.
  - If add_done_in arrives in the same cycle as the expiry, the result wins.
- Undefined:
  - WAIT has no limit.
  - err_out is tied to 0 and the watchdog logic is absent.

Decomposition:
- Shared package fp_add_pkg holds:
  - the state enum;
  - the WIDTH default;
  - a localparam for counter width, $clog2(WIDTH+1).
- One natural sub-module, fp_add_ser_out: the result parallel-to-serial register with valid/ready and bit counter. The FSM and load counting stay in the top.

Test Plan:
1. Stream A=0x3F800000 then B=0x40000000, LSB first; the adder model returns 0x40400000 3 cycles after start.
   -> 32 a_wr_out and 32 b_wr_out pulses, one add_start_out pulse, then result bits 0x40400000 LSB first, then IDLE.
2. Hold res_rdy_in low for 5 cycles at result bit 7.
   -> res_serial_out and res_valid_out stay stable; bit_cnt is unchanged; the transfer completes correctly afterwards.
3. Pulse host_wr_in during WAIT and SHIFT_OUT.
   -> no a_wr_out or b_wr_out strobes; host_rdy_out=0; the result is unaffected.
4. Assert rst_in low after 20 B bits.
   -> immediately IDLE with all outputs 0 except host_rdy_out=1; a fresh 64-bit load then produces the correct sum.
5. With FP_ADD_SEQ_TIMEOUT_EN and TIMEOUT=64, the adder never responds.
   -> err_out=1 at cycle 64 of WAIT, state returns to IDLE, and the next accepted host bit clears err_out.
6. Drive add_done_in during START.
   -> the pulse is ignored; the result is captured only on a later done in WAIT.
